// File: rtl/min_sec_counter_if.sv
// min_sec_counter_if: bundles the min:sec counter's control strobes and BCD/strobe outputs.
// Ports: tick_1hz, run, clear, min_inc (to counter); sec_ones, sec_tens, min_ones,
//        min_tens, min_tick, wrap_tick (from counter); seg_* only with MIN_SEC_SEG7_EN.
interface min_sec_counter_if;
  logic       tick_1hz;
  logic       run;
  logic       clear;
  logic       min_inc;
  logic [3:0] sec_ones;
  logic [3:0] sec_tens;
  logic [3:0] min_ones;
  logic [3:0] min_tens;
  logic       min_tick;
  logic       wrap_tick;
`ifdef MIN_SEC_SEG7_EN
  logic [6:0] seg_sec_ones;
  logic [6:0] seg_sec_tens;
  logic [6:0] seg_min_ones;
  logic [6:0] seg_min_tens;
`endif

  // master: the stage driving the controls and consuming the count
  modport master (
    output tick_1hz, run, clear, min_inc,
    input  sec_ones, sec_tens, min_ones, min_tens, min_tick, wrap_tick
`ifdef MIN_SEC_SEG7_EN
    , input seg_sec_ones, seg_sec_tens, seg_min_ones, seg_min_tens
`endif
  );

  // slave: the counter itself
  modport slave (
    input  tick_1hz, run, clear, min_inc,
    output sec_ones, sec_tens, min_ones, min_tens, min_tick, wrap_tick
`ifdef MIN_SEC_SEG7_EN
    , output seg_sec_ones, seg_sec_tens, seg_min_ones, seg_min_tens
`endif
  );
endinterface

// File: rtl/min_sec_counter.sv
// min_sec_counter: BCD mm:ss counter advanced by the 1 Hz tick, with minute/wrap carry strobes.
// Latency: one clk_50mhz cycle from sampled input to digits/strobes; seg7 outputs one more.
// Backpressure: none; strobes are consumed as they arrive, ticks while paused are dropped.
// Ports: clk_50mhz, reset (async, active high), bus (min_sec_counter_if.slave).
// Optional MIN_SEC_SEG7_EN adds registered active-low {g,f,e,d,c,b,a} decodes of each digit.
module min_sec_counter #(
  parameter int MAX_MIN = 59
) (
  input logic              clk_50mhz,
  input logic              reset,
  min_sec_counter_if.slave bus
);
  localparam logic [3:0] MAX_TENS = 4'(MAX_MIN / 10);
  localparam logic [3:0] MAX_ONES = 4'(MAX_MIN % 10);

  logic [3:0] sec_ones_q, sec_tens_q, min_ones_q, min_tens_q;
  logic       min_tick_q, wrap_tick_q;

  logic       sec_ev;
  logic       sec_carry;
  logic [3:0] sec_ones_d, sec_tens_d;
  logic [3:0] min_ones_d, min_tens_d;
  logic [8:0] min_step1, min_step2;
  logic       wrap_d;

  // One BCD minute step: returns {wrapped, tens, ones}. Out-of-range values load 00
  // without flagging a wrap.
  function automatic logic [8:0] min_step(input logic [3:0] tens, input logic [3:0] ones);
    logic [8:0] r;
    if (tens == MAX_TENS && ones == MAX_ONES)
      r = {1'b1, 8'h00};
    else if (tens > 4'd9 || ones > 4'd9 || (int'(tens) * 10 + int'(ones)) > MAX_MIN)
      r = 9'h000;
    else if (ones == 4'd9)
      r = {1'b0, tens + 4'd1, 4'd0};
    else
      r = {1'b0, tens, ones + 4'd1};
    return r;
  endfunction

  always_comb begin
    sec_ev     = bus.tick_1hz & bus.run;
    sec_carry  = 1'b0;
    sec_ones_d = sec_ones_q;
    sec_tens_d = sec_tens_q;
    if (sec_ev) begin
      if (sec_ones_q > 4'd9 || sec_tens_q > 4'd5) begin
        sec_ones_d = 4'd0;
        sec_tens_d = 4'd0;
      end else if (sec_ones_q == 4'd9) begin
        sec_ones_d = 4'd0;
        if (sec_tens_q == 4'd5) begin
          sec_tens_d = 4'd0;
          sec_carry  = 1'b1;
        end else begin
          sec_tens_d = sec_tens_q + 4'd1;
        end
      end else begin
        sec_ones_d = sec_ones_q + 4'd1;
      end
    end

    // Carry and min_inc together advance two minutes: chain two single steps.
    min_step1  = min_step(min_tens_q, min_ones_q);
    min_step2  = min_step(min_step1[7:4], min_step1[3:0]);
    min_tens_d = min_tens_q;
    min_ones_d = min_ones_q;
    wrap_d     = 1'b0;
    if (sec_carry && bus.min_inc) begin
      {min_tens_d, min_ones_d} = min_step2[7:0];
      wrap_d = min_step1[8] | min_step2[8];
    end else if (sec_carry || bus.min_inc) begin
      {min_tens_d, min_ones_d} = min_step1[7:0];
      // A wrap from set-mode increments alone is not a count rollover.
      wrap_d = sec_carry & min_step1[8];
    end
  end

  always_ff @(posedge clk_50mhz or posedge reset) begin
    if (reset) begin
      sec_ones_q  <= 4'd0;
      sec_tens_q  <= 4'd0;
      min_ones_q  <= 4'd0;
      min_tens_q  <= 4'd0;
      min_tick_q  <= 1'b0;
      wrap_tick_q <= 1'b0;
    end else if (bus.clear) begin
      sec_ones_q  <= 4'd0;
      sec_tens_q  <= 4'd0;
      min_ones_q  <= 4'd0;
      min_tens_q  <= 4'd0;
      min_tick_q  <= 1'b0;
      wrap_tick_q <= 1'b0;
    end else begin
      sec_ones_q  <= sec_ones_d;
      sec_tens_q  <= sec_tens_d;
      min_ones_q  <= min_ones_d;
      min_tens_q  <= min_tens_d;
      min_tick_q  <= sec_carry;
      wrap_tick_q <= wrap_d;
    end
  end

  assign bus.sec_ones  = sec_ones_q;
  assign bus.sec_tens  = sec_tens_q;
  assign bus.min_ones  = min_ones_q;
  assign bus.min_tens  = min_tens_q;
  assign bus.min_tick  = min_tick_q;
  assign bus.wrap_tick = wrap_tick_q;

`ifdef MIN_SEC_SEG7_EN
  // Active-low {g,f,e,d,c,b,a}; non-BCD codes show blank.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  logic [6:0] seg_sec_ones_q, seg_sec_tens_q, seg_min_ones_q, seg_min_tens_q;

  // Decoded from the digit registers, so segments trail the digits by one cycle.
  always_ff @(posedge clk_50mhz or posedge reset) begin
    if (reset) begin
      seg_sec_ones_q <= 7'h7F;
      seg_sec_tens_q <= 7'h7F;
      seg_min_ones_q <= 7'h7F;
      seg_min_tens_q <= 7'h7F;
    end else begin
      seg_sec_ones_q <= seg7(sec_ones_q);
      seg_sec_tens_q <= seg7(sec_tens_q);
      seg_min_ones_q <= seg7(min_ones_q);
      seg_min_tens_q <= seg7(min_tens_q);
    end
  end

  assign bus.seg_sec_ones = seg_sec_ones_q;
  assign bus.seg_sec_tens = seg_sec_tens_q;
  assign bus.seg_min_ones = seg_min_ones_q;
  assign bus.seg_min_tens = seg_min_tens_q;
`endif
endmodule
